// File: rtl/rename_stage.sv
// Register-rename stage: maps architectural sources and destinations onto
// physical tags through a RAT and a circular free list. The renamed
// instruction is registered for dispatch. Decode is stalled when the output
// register is occupied or when a destination needs a tag and none is free.
module rename_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PREG_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_alu_op,
    input  logic [31:0]       in_imm,
    input  logic              in_alu_src,
    input  logic              in_mem_to_reg,
    input  logic              in_mem_read,
    input  logic              in_mem_write,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_prs1,
    output logic [PREG_W-1:0] out_prs2,
    output logic [PREG_W-1:0] out_prd,
    output logic [PREG_W-1:0] out_old_prd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_alu_op,
    output logic [31:0]       out_imm,
    output logic              out_alu_src,
    output logic              out_mem_to_reg,
    output logic              out_mem_read,
    output logic              out_mem_write,

    input  logic              retire_valid,
    input  logic [PREG_W-1:0] retire_preg,
    output logic [5:0]        free_count,
    output logic              overflow_err
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_AW    = $clog2(FL_DEPTH);

    logic [PREG_W-1:0] rat [ARCH_REGS];
    logic [PREG_W-1:0] fl  [FL_DEPTH];
    logic [FL_AW-1:0]  head;
    logic [FL_AW-1:0]  tail;

    logic              alloc;
    logic              accept;
    logic              fl_full;
    logic              push;
    logic [PREG_W-1:0] rd_prs1;
    logic [PREG_W-1:0] rd_prs2;

    // Handshake, allocation and retire-acceptance decisions; x0 always reads p0.
    always_comb begin
        alloc    = in_reg_write && (in_rd != 5'd0);
        in_ready = (!out_valid || out_ready) && (!alloc || (free_count != '0));
        accept   = in_valid && in_ready;
        fl_full  = (free_count == 6'(FL_DEPTH));
        push     = retire_valid && (retire_preg != '0) && !fl_full;
        rd_prs1  = (in_rs1 == 5'd0) ? '0 : rat[in_rs1];
        rd_prs2  = (in_rs2 == 5'd0) ? '0 : rat[in_rs2];
    end

    // RAT: identity after reset, rd remapped to the free-list head on allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (accept && alloc) begin
            rat[in_rd] <= fl[head];
        end
    end

    // Free list: pop at head on allocation, push retired tags at tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PREG_W'(ARCH_REGS + i);
            end
            head         <= '0;
            tail         <= '0;
            free_count   <= 6'(FL_DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (accept && alloc) begin
                head <= head + 1'b1;
            end
            if (push) begin
                fl[tail] <= retire_preg;
                tail     <= tail + 1'b1;
            end
            if (retire_valid && (retire_preg != '0) && fl_full) begin
                overflow_err <= 1'b1;
            end
            case ({accept && alloc, push})
                2'b10:   free_count <= free_count - 1'b1;
                2'b01:   free_count <= free_count + 1'b1;
                default: free_count <= free_count;
            endcase
        end
    end

    // Output register: loads on accept, drains when dispatch consumes, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_prs1       <= '0;
            out_prs2       <= '0;
            out_prd        <= '0;
            out_old_prd    <= '0;
            out_opcode     <= '0;
            out_alu_op     <= '0;
            out_imm        <= '0;
            out_alu_src    <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_prs1       <= rd_prs1;
            out_prs2       <= rd_prs2;
            out_prd        <= alloc ? fl[head] : '0;
            out_old_prd    <= alloc ? rat[in_rd] : '0;
            out_opcode     <= in_opcode;
            out_alu_op     <= in_alu_op;
            out_imm        <= in_imm;
            out_alu_src    <= in_alu_src;
            out_mem_to_reg <= in_mem_to_reg;
            out_mem_read   <= in_mem_read;
            out_mem_write  <= in_mem_write;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: hand-computed tags for allocation,
// dependence, exhaustion/retire, x0 handling, backpressure, overflow and reset.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_reg_write;
    logic [6:0]  in_opcode;
    logic [2:0]  in_alu_op;
    logic [31:0] in_imm;
    logic        in_alu_src, in_mem_to_reg, in_mem_read, in_mem_write;
    logic        out_valid, out_ready;
    logic [5:0]  out_prs1, out_prs2, out_prd, out_old_prd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_alu_op;
    logic [31:0] out_imm;
    logic        out_alu_src, out_mem_to_reg, out_mem_read, out_mem_write;
    logic        retire_valid;
    logic [5:0]  retire_preg;
    logic [5:0]  free_count;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;

    rename_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_opcode(in_opcode),
        .in_alu_op(in_alu_op), .in_imm(in_imm),
        .in_alu_src(in_alu_src), .in_mem_to_reg(in_mem_to_reg),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2),
        .out_prd(out_prd), .out_old_prd(out_old_prd),
        .out_opcode(out_opcode), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .retire_valid(retire_valid), .retire_preg(retire_preg),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_reg_write = 1'b0;
        in_opcode = '0; in_alu_op = '0; in_imm = '0;
        in_alu_src = 1'b0; in_mem_to_reg = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        out_ready = 1'b1; retire_valid = 1'b0; retire_preg = '0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_free_count", free_count, 32);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_out_prd", out_prd, 0);
        rst_n = 1'b1;

        // add x5,x1,x2
        in_opcode = 7'h33; in_alu_op = 3'd3; in_imm = 32'hdeadbeef; in_alu_src = 1'b1;
        drive(5'd1, 5'd2, 5'd5, 1'b1);
        #1 chk("t1_in_ready", in_ready, 1);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_prs1", out_prs1, 1);
        chk("t1_prs2", out_prs2, 2);
        chk("t1_prd", out_prd, 32);
        chk("t1_old", out_old_prd, 5);
        chk("t1_count", free_count, 31);
        chk("t1_opcode", out_opcode, 7'h33);
        chk("t1_alu_op", out_alu_op, 3);
        chk("t1_imm", out_imm, 32'hdeadbeef);
        chk("t1_alu_src", out_alu_src, 1);

        // add x5,x5,x5 back to back
        in_alu_src = 1'b0;
        drive(5'd5, 5'd5, 5'd5, 1'b1);
        tick();
        chk("t2_prs1", out_prs1, 32);
        chk("t2_prs2", out_prs2, 32);
        chk("t2_prd", out_prd, 33);
        chk("t2_old", out_old_prd, 32);
        chk("t2_count", free_count, 30);

        // exhaust: rd x1..x30 get p34..p63
        for (int i = 0; i < 30; i++) begin
            drive(5'd0, 5'd0, 5'(i + 1), 1'b1);
            tick();
        end
        chk("t3_last_prd", out_prd, 63);
        chk("t3_count0", free_count, 0);
        drive(5'd0, 5'd0, 5'd7, 1'b1);
        #1 chk("t3_stall_ready", in_ready, 0);
        tick();
        chk("t3_stall_valid", out_valid, 0);
        chk("t3_stall_count", free_count, 0);

        // store with no destination still goes through
        in_mem_write = 1'b1;
        drive(5'd5, 5'd6, 5'd9, 1'b0);
        #1 chk("t3_sw_ready", in_ready, 1);
        tick();
        chk("t3_sw_valid", out_valid, 1);
        chk("t3_sw_prd", out_prd, 0);
        chk("t3_sw_old", out_old_prd, 0);
        chk("t3_sw_prs1", out_prs1, 38);
        chk("t3_sw_prs2", out_prs2, 39);
        chk("t3_sw_memw", out_mem_write, 1);
        in_mem_write = 1'b0;

        // retire p7 while an alloc waits
        drive(5'd3, 5'd0, 5'd3, 1'b1);
        retire_valid = 1'b1; retire_preg = 6'd7;
        #1 chk("t3_ret_same_cycle_ready", in_ready, 0);
        tick();
        retire_valid = 1'b0;
        chk("t3_ret_count", free_count, 1);
        chk("t3_ret_ready", in_ready, 1);
        tick();
        chk("t3_new_prd", out_prd, 7);
        chk("t3_new_old", out_old_prd, 36);
        chk("t3_rd_eq_rs1", out_prs1, 36);
        chk("t3_new_count", free_count, 0);

        // rd = x0
        drive(5'd0, 5'd3, 5'd0, 1'b1);
        tick();
        chk("t4_prd", out_prd, 0);
        chk("t4_old", out_old_prd, 0);
        chk("t4_prs1", out_prs1, 0);
        chk("t4_prs2", out_prs2, 7);
        chk("t4_count", free_count, 0);

        // backpressure
        out_ready = 1'b0;
        in_opcode = 7'h13;
        drive(5'd3, 5'd5, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_hold_ready", in_ready, 0);
            tick();
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_prs2", out_prs2, 7);
            chk("t5_hold_opcode", out_opcode, 7'h33);
        end
        out_ready = 1'b1;
        #1 chk("t5_release_ready", in_ready, 1);
        tick();
        chk("t5_next_prs1", out_prs1, 7);
        chk("t5_next_prs2", out_prs2, 38);
        chk("t5_next_opcode", out_opcode, 7'h13);

        // reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", free_count, 32);
        chk("t6_rst_prs1", out_prs1, 0);
        rst_n = 1'b1;
        drive(5'd5, 5'd30, 5'd0, 1'b0);
        tick();
        chk("t6_ident_prs1", out_prs1, 5);
        chk("t6_ident_prs2", out_prs2, 30);

        // overflow on a full free list
        in_valid = 1'b0;
        retire_valid = 1'b1; retire_preg = 6'd9;
        tick();
        retire_valid = 1'b0;
        chk("t6_ovf_count", free_count, 32);
        chk("t6_ovf_flag", overflow_err, 1);

        drive(5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        chk("t6_alloc_prd", out_prd, 32);
        chk("t6_alloc_old", out_old_prd, 4);
        chk("t6_alloc_count", free_count, 31);

        // simultaneous allocate and retire
        drive(5'd4, 5'd0, 5'd6, 1'b1);
        retire_valid = 1'b1; retire_preg = 6'd50;
        tick();
        chk("t6_sim_prd", out_prd, 33);
        chk("t6_sim_prs1", out_prs1, 32);
        chk("t6_sim_count", free_count, 31);
        chk("t6_sticky", overflow_err, 1);

        // retiring p0 is ignored
        in_valid = 1'b0;
        retire_preg = 6'd0;
        tick();
        retire_valid = 1'b0;
        chk("t6_p0_count", free_count, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
